// File: rtl/reg_scoreboard_pkg.sv
// Register map and scoreboard shared types for the issue-gating scoreboard.
// Purpose : architectural register ids, scoreboard sizing, FSM state enum, id->mask helper.
// Ports   : none (packages only).

package RegMap;
   // 8-bit architectural register id: rax..r15 = 0..15, rflags = 16, rh0 = 17.
   typedef logic [7:0] reg_id_t;

   localparam reg_id_t REG_RAX    = 8'd0;
   localparam reg_id_t REG_RCX    = 8'd1;
   localparam reg_id_t REG_RDX    = 8'd2;
   localparam reg_id_t REG_RBX    = 8'd3;
   localparam reg_id_t REG_RSP    = 8'd4;
   localparam reg_id_t REG_RBP    = 8'd5;
   localparam reg_id_t REG_RSI    = 8'd6;
   localparam reg_id_t REG_RDI    = 8'd7;
   localparam reg_id_t REG_R8     = 8'd8;
   localparam reg_id_t REG_RFLAGS = 8'd16;
   localparam reg_id_t REG_RH0    = 8'd17;
endpackage

package ScoreboardPkg;
   import RegMap::reg_id_t;

   localparam int NUM_REGS = 32;  // ids 0..NUM_REGS-1 tracked; must cover rh0 (17)
   localparam int SRC_CNT  = 3;   // 2 GPR sources + rflags
   localparam int DST_CNT  = 2;   // GPR destination + rflags
   localparam int WB_PORTS = 2;

   typedef logic [NUM_REGS-1:0] reg_mask_t;

   typedef enum logic {
      SB_RUN   = 1'b0,
      SB_DRAIN = 1'b1
   } sb_state_t;

   function automatic logic id_in_range(input reg_id_t id);
      return int'(id) < NUM_REGS;
   endfunction

   // One-hot mask for a register id; zero when the slot is invalid or the
   // id is outside the tracked range (such ids are never busy).
   function automatic reg_mask_t id2mask(input reg_id_t id, input logic vld);
      reg_mask_t m;
      m = '0;
      if (vld && id_in_range(id))
         m = reg_mask_t'(1) << id;
      return m;
   endfunction
endpackage

// File: rtl/reg_hazard_check.sv
// Purpose : combinational RAW/WAW hazard and bad-id detection for one issuing instruction.
// Latency : purely combinational, zero cycles.
// Ports   : eff_busy (bypassed busy bits), src/dst ids + valids in; hazard, bad_id out.

module reg_hazard_check
   import RegMap::*;
   import ScoreboardPkg::*;
(
   input  logic [NUM_REGS-1:0]         eff_busy,
   input  logic [SRC_CNT-1:0]          src_vld,
   input  logic [SRC_CNT-1:0][7:0]     src,
   input  logic [DST_CNT-1:0]          dst_vld,
   input  logic [DST_CNT-1:0][7:0]     dst,
   output logic                        hazard,
   output logic                        bad_id
);

   reg_mask_t src_mask;
   reg_mask_t dst_mask;

   always_comb begin
      src_mask = '0;
      dst_mask = '0;
      bad_id   = 1'b0;
      for (int i = 0; i < SRC_CNT; i++) begin
         src_mask = src_mask | id2mask(src[i], src_vld[i]);
         if (src_vld[i] && !id_in_range(src[i]))
            bad_id = 1'b1;
      end
      for (int i = 0; i < DST_CNT; i++) begin
         dst_mask = dst_mask | id2mask(dst[i], dst_vld[i]);
         if (dst_vld[i] && !id_in_range(dst[i]))
            bad_id = 1'b1;
      end
   end

   // RAW: a source still waiting on its producer.
   // WAW: a destination with an older write still in flight.
   assign hazard = |((src_mask | dst_mask) & eff_busy);

endmodule

// File: rtl/reg_scoreboard.sv
// Purpose : per-register busy scoreboard gating decode->execute issue, with drain/quiesce FSM.
// Latency : iss_ready combinational (writeback bypassed same cycle); busy set one edge after fire.
// Ports   : iss_* issue handshake and operand ids; wb_* writeback clears; drain_req/drain_done
//           quiesce handshake; busy_vec, stall_cnt, sticky err_bad_id / err_spurious_wb status.

module reg_scoreboard
   import RegMap::*;
   import ScoreboardPkg::*;
(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        iss_valid,
   output logic                        iss_ready,
   input  logic [SRC_CNT-1:0]          iss_src_vld,
   input  logic [SRC_CNT-1:0][7:0]     iss_src,
   input  logic [DST_CNT-1:0]          iss_dst_vld,
   input  logic [DST_CNT-1:0][7:0]     iss_dst,
   input  logic [WB_PORTS-1:0]         wb_valid,
   input  logic [WB_PORTS-1:0][7:0]    wb_reg,
   input  logic                        drain_req,
   output logic                        drain_done,
   output logic [NUM_REGS-1:0]         busy_vec,
   output logic [31:0]                 stall_cnt,
   output logic                        err_bad_id,
   output logic                        err_spurious_wb
);

   sb_state_t state;
   sb_state_t state_next;

   reg_mask_t wb_clear_mask;
   reg_mask_t eff_busy;
   reg_mask_t fire_set_mask;
   reg_mask_t busy_next;
   logic      wb_bad_id;
   logic      wb_spurious;
   logic      hz_hazard;
   logic      hz_bad_id;
   logic      fire;
   logic      drain_done_next;

   // ---------------------------------------------------------------
   // Writeback decode. Duplicate ids on both ports collapse into one
   // clear. A spurious writeback is judged against the registered
   // busy bits, so two ports naming the same busy reg is not an error.
   // ---------------------------------------------------------------
   always_comb begin
      wb_clear_mask = '0;
      wb_bad_id     = 1'b0;
      wb_spurious   = 1'b0;
      for (int i = 0; i < WB_PORTS; i++) begin
         wb_clear_mask = wb_clear_mask | id2mask(wb_reg[i], wb_valid[i]);
         if (wb_valid[i]) begin
            if (!id_in_range(wb_reg[i]))
               wb_bad_id = 1'b1;
            else if ((busy_vec & id2mask(wb_reg[i], 1'b1)) == '0)
               wb_spurious = 1'b1;
         end
      end
   end

   // Bypass: a register completing this cycle no longer blocks issue.
   assign eff_busy = busy_vec & ~wb_clear_mask;

   reg_hazard_check u_hazard (
      .eff_busy (eff_busy),
      .src_vld  (iss_src_vld),
      .src      (iss_src),
      .dst_vld  (iss_dst_vld),
      .dst      (iss_dst),
      .hazard   (hz_hazard),
      .bad_id   (hz_bad_id)
   );

   assign fire = iss_valid && iss_ready;

   always_comb begin
      fire_set_mask = '0;
      if (fire) begin
         for (int i = 0; i < DST_CNT; i++)
            fire_set_mask = fire_set_mask | id2mask(iss_dst[i], iss_dst_vld[i]);
      end
   end

   // Set after clear: a new write of a register wins over the completion
   // of its previous write in the same cycle.
   assign busy_next = eff_busy | fire_set_mask;

   // ---------------------------------------------------------------
   // FSM: state register / next-state / outputs
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= SB_RUN;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         SB_RUN:   if (drain_req)        state_next = SB_DRAIN;
         SB_DRAIN: if (busy_next == '0)  state_next = SB_RUN;
         default:                        state_next = SB_RUN;
      endcase
   end

   always_comb begin
      iss_ready       = 1'b0;
      drain_done_next = 1'b0;
      case (state)
         SB_RUN:   iss_ready       = !hz_hazard;
         SB_DRAIN: drain_done_next = (busy_next == '0);
         default: ;
      endcase
   end

   // ---------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_vec   <= '0;
         drain_done <= 1'b0;
      end else begin
         busy_vec   <= busy_next;
         drain_done <= drain_done_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_cnt <= '0;
      else if (iss_valid && !iss_ready && (stall_cnt != 32'hFFFF_FFFF))
         stall_cnt <= stall_cnt + 32'd1;
   end

   // Sticky error flags; only reset clears them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_bad_id      <= 1'b0;
         err_spurious_wb <= 1'b0;
      end else begin
         if (hz_bad_id || wb_bad_id)
            err_bad_id <= 1'b1;
         if (wb_spurious)
            err_spurious_wb <= 1'b1;
      end
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: inputs driven on the falling edge,
// combinational outputs sampled 1ns later, registered outputs sampled on
// the next falling edge.

module tb_reg_scoreboard;
   import RegMap::*;
   import ScoreboardPkg::*;

   logic                     clk;
   logic                     reset;
   logic                     iss_valid;
   logic                     iss_ready;
   logic [SRC_CNT-1:0]       iss_src_vld;
   logic [SRC_CNT-1:0][7:0]  iss_src;
   logic [DST_CNT-1:0]       iss_dst_vld;
   logic [DST_CNT-1:0][7:0]  iss_dst;
   logic [WB_PORTS-1:0]      wb_valid;
   logic [WB_PORTS-1:0][7:0] wb_reg;
   logic                     drain_req;
   logic                     drain_done;
   logic [NUM_REGS-1:0]      busy_vec;
   logic [31:0]              stall_cnt;
   logic                     err_bad_id;
   logic                     err_spurious_wb;

   int checks = 0;
   int errors = 0;

   reg_scoreboard dut (
      .clk             (clk),
      .reset           (reset),
      .iss_valid       (iss_valid),
      .iss_ready       (iss_ready),
      .iss_src_vld     (iss_src_vld),
      .iss_src         (iss_src),
      .iss_dst_vld     (iss_dst_vld),
      .iss_dst         (iss_dst),
      .wb_valid        (wb_valid),
      .wb_reg          (wb_reg),
      .drain_req       (drain_req),
      .drain_done      (drain_done),
      .busy_vec        (busy_vec),
      .stall_cnt       (stall_cnt),
      .err_bad_id      (err_bad_id),
      .err_spurious_wb (err_spurious_wb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      iss_valid   = 1'b0;
      iss_src_vld = '0;
      iss_src     = '0;
      iss_dst_vld = '0;
      iss_dst     = '0;
      wb_valid    = '0;
      wb_reg      = '0;
      drain_req   = 1'b0;
   endtask

   // advance to the next falling edge (registered outputs of the rising edge visible)
   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      #12;
      chk("rst_busy", busy_vec, 32'h0);
      chk("rst_stall", stall_cnt, 32'd0);
      chk("rst_drain_done", drain_done, 1'b0);
      chk("rst_err_bad", err_bad_id, 1'b0);
      chk("rst_err_spur", err_spurious_wb, 1'b0);
      chk("rst_ready", iss_ready, 1'b1);
      cyc();
      reset = 1'b0;

      // ---- issue dst=rax, then RAW stall on rax, bypass on wb ----
      cyc();
      iss_valid = 1'b1; iss_dst_vld = 2'b01; iss_dst[0] = REG_RAX;
      #1 chk("t1_ready_dst_rax", iss_ready, 1'b1);
      cyc();
      chk("t1_busy_rax", busy_vec, 32'h1);
      idle_inputs();
      iss_valid = 1'b1; iss_src_vld = 3'b001; iss_src[0] = REG_RAX;
      #1 chk("t1_raw_stall", iss_ready, 1'b0);
      cyc();
      chk("t1_stall_1", stall_cnt, 32'd1);
      cyc();
      chk("t1_stall_2", stall_cnt, 32'd2);
      wb_valid = 2'b01; wb_reg[0] = REG_RAX;
      #1 chk("t1_wb_bypass", iss_ready, 1'b1);
      cyc();
      chk("t1_stall_hold", stall_cnt, 32'd2);
      chk("t1_busy_clear", busy_vec, 32'h0);
      idle_inputs();

      // ---- set wins over same-cycle clear (rcx) ----
      iss_valid = 1'b1; iss_dst_vld = 2'b01; iss_dst[0] = REG_RCX;
      cyc();
      chk("t2_busy_rcx", busy_vec, 32'h2);
      iss_valid = 1'b1; iss_dst_vld = 2'b01; iss_dst[0] = REG_RCX;
      wb_valid = 2'b01; wb_reg[0] = REG_RCX;
      #1 chk("t2_ready_waw_bypass", iss_ready, 1'b1);
      cyc();
      chk("t2_set_wins", busy_vec, 32'h2);
      chk("t2_no_spur", err_spurious_wb, 1'b0);
      chk("t2_no_bad", err_bad_id, 1'b0);
      idle_inputs();
      wb_valid = 2'b01; wb_reg[0] = REG_RCX;
      cyc();
      chk("t2_rcx_clear", busy_vec, 32'h0);
      idle_inputs();

      // ---- dst {r8, rflags}; partial wb keeps rflags busy ----
      iss_valid = 1'b1; iss_dst_vld = 2'b11; iss_dst[0] = REG_R8; iss_dst[1] = REG_RFLAGS;
      cyc();
      chk("t3_busy_r8_flags", busy_vec, 32'h0001_0100);
      idle_inputs();
      iss_valid = 1'b1; iss_src_vld = 3'b100; iss_src[2] = REG_RFLAGS;
      wb_valid = 2'b01; wb_reg[0] = REG_R8;
      #1 chk("t3_flags_stall", iss_ready, 1'b0);
      cyc();
      chk("t3_stall_3", stall_cnt, 32'd3);
      chk("t3_busy_flags", busy_vec, 32'h0001_0000);
      wb_reg[0] = REG_RFLAGS;
      #1 chk("t3_flags_bypass", iss_ready, 1'b1);
      cyc();
      chk("t3_busy_clear", busy_vec, 32'h0);
      idle_inputs();

      // ---- duplicate dst ids and duplicate wb ids ----
      iss_valid = 1'b1; iss_dst_vld = 2'b11; iss_dst[0] = REG_RBP; iss_dst[1] = REG_RBP;
      cyc();
      chk("t4_dup_dst", busy_vec, 32'h20);
      idle_inputs();
      wb_valid = 2'b11; wb_reg[0] = REG_RBP; wb_reg[1] = REG_RBP;
      cyc();
      chk("t4_dup_wb", busy_vec, 32'h0);
      chk("t4_dup_wb_no_spur", err_spurious_wb, 1'b0);
      idle_inputs();

      // ---- rsp as src and dst of the same op is legal ----
      iss_valid = 1'b1; iss_src_vld = 3'b001; iss_src[0] = REG_RSP;
      iss_dst_vld = 2'b01; iss_dst[0] = REG_RSP;
      #1 chk("t4_rsp_push_ready", iss_ready, 1'b1);
      cyc();
      chk("t4_rsp_busy", busy_vec, 32'h10);
      idle_inputs();
      wb_valid = 2'b01; wb_reg[0] = REG_RSP;
      cyc();
      idle_inputs();

      // ---- drain with rbx, rsi busy ----
      iss_valid = 1'b1; iss_dst_vld = 2'b11; iss_dst[0] = REG_RBX; iss_dst[1] = REG_RSI;
      cyc();
      chk("t5_busy_rbx_rsi", busy_vec, 32'h48);
      idle_inputs();
      drain_req = 1'b1;
      cyc();
      idle_inputs();
      iss_valid = 1'b1;
      wb_valid = 2'b01; wb_reg[0] = REG_RBX;
      #1 chk("t5_drain_blocks", iss_ready, 1'b0);
      cyc();
      chk("t5_stall_4", stall_cnt, 32'd4);
      chk("t5_busy_rsi", busy_vec, 32'h40);
      chk("t5_no_done_1", drain_done, 1'b0);
      idle_inputs();
      cyc();
      chk("t5_no_done_2", drain_done, 1'b0);
      wb_valid = 2'b01; wb_reg[0] = REG_RSI;
      #1 chk("t5_still_draining", iss_ready, 1'b0);
      cyc();
      idle_inputs();
      #1;
      chk("t5_done_pulse", drain_done, 1'b1);
      chk("t5_busy_empty", busy_vec, 32'h0);
      chk("t5_back_to_run", iss_ready, 1'b1);
      cyc();
      chk("t5_done_single", drain_done, 1'b0);

      // ---- drain from idle: 2-cycle round trip ----
      drain_req = 1'b1;
      cyc();
      drain_req = 1'b0;
      #1;
      chk("t6_in_drain", iss_ready, 1'b0);
      chk("t6_no_done_yet", drain_done, 1'b0);
      cyc();
      chk("t6_done_pulse", drain_done, 1'b1);
      chk("t6_run_ready", iss_ready, 1'b1);
      cyc();
      chk("t6_done_single", drain_done, 1'b0);

      // ---- bad ids and spurious writeback ----
      iss_src_vld = 3'b001; iss_src[0] = 8'd200;
      cyc();
      chk("t7_bad_id", err_bad_id, 1'b1);
      chk("t7_no_spur", err_spurious_wb, 1'b0);
      idle_inputs();
      cyc();
      chk("t7_bad_id_sticky", err_bad_id, 1'b1);
      iss_valid = 1'b1; iss_dst_vld = 2'b11; iss_dst[0] = REG_RAX; iss_dst[1] = 8'd200;
      #1 chk("t7_oor_dst_ready", iss_ready, 1'b1);
      cyc();
      chk("t7_oor_never_set", busy_vec, 32'h1);
      idle_inputs();
      wb_valid = 2'b01; wb_reg[0] = REG_RDX;
      cyc();
      chk("t7_spur_wb", err_spurious_wb, 1'b1);
      chk("t7_spur_no_change", busy_vec, 32'h1);
      idle_inputs();
      wb_valid = 2'b01; wb_reg[0] = REG_RAX;
      cyc();
      idle_inputs();

      // ---- reset during drain with busy_vec = 0x5 ----
      iss_valid = 1'b1; iss_dst_vld = 2'b11; iss_dst[0] = REG_RAX; iss_dst[1] = REG_RDX;
      cyc();
      chk("t8_busy_5", busy_vec, 32'h5);
      idle_inputs();
      drain_req = 1'b1;
      cyc();
      drain_req = 1'b0;
      #1 chk("t8_draining", iss_ready, 1'b0);
      reset = 1'b1;
      #1;
      chk("t8_rst_busy", busy_vec, 32'h0);
      chk("t8_rst_errs", {err_bad_id, err_spurious_wb}, 2'b00);
      chk("t8_rst_stall", stall_cnt, 32'd0);
      cyc();
      reset = 1'b0;
      #1 chk("t8_ready_after_rst", iss_ready, 1'b1);
      cyc();
      chk("t8_no_done_1", drain_done, 1'b0);
      cyc();
      chk("t8_no_done_2", drain_done, 1'b0);
      chk("t8_busy_still_0", busy_vec, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
